// File: rtl/bcd_down_ctr_pkg.sv
// Purpose : shared BCD constants and digit helpers for the BCD up/down counters
//           and their display decode path.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: BCD_MAX, BCD_ZERO, DIGITS_MAX, bcd_valid(), bcd_dec().
package bcd_down_ctr_pkg;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] BCD_ZERO   = 4'd0;
  localparam int         DIGITS_MAX = 8;

  // A nibble is a legal BCD digit only in 0..9; A..F are rejected.
  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

  // One decade step downwards: 0 borrows round to 9, anything else drops by one.
  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == BCD_ZERO) ? BCD_MAX : (d - 4'd1);
  endfunction

endpackage

// File: rtl/bcd_down_ctr_digit.sv
// Purpose : one BCD decade of the down counter (bcd_dn_digit).
// Latency : 1 cycle from ld/step to d.
// Backpressure: none; the digit only moves when step and borrow_in_ok are both high.
// Ports   : clk, res (async active-low), ld/ld_val parallel load, step (counter is
//           decrementing this cycle), borrow_in_ok (all lower digits are zero),
//           d (digit value), is_zero (d == 0, combinational from d).
module bcd_dn_digit
  import bcd_down_ctr_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       borrow_in_ok,
  output logic [3:0] d,
  output logic       is_zero
);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      d <= BCD_ZERO;
    end else if (ld) begin
      d <= ld_val;
    end else if (step && borrow_in_ok) begin
      d <= bcd_dec(d);
    end
  end

  assign is_zero = (d == BCD_ZERO);

endmodule

// File: rtl/bcd_down_ctr.sv
// Purpose : cascadable DIGITS-decade BCD down counter with parallel load, used as a
//           programmable interval/timeout timer with terminal-count pulse.
// Latency : 1 cycle from load/en to q, tc, err; zero is combinational from q.
// Backpressure: none; en=0 freezes the count, load always wins over en.
// Ports   : clk; res (async active-low); en count enable; load parallel-load strobe;
//           din load value (digit i at [4i+3:4i]); wrap (1: 0 -> all nines, 0: hold
//           at 0); q current count; zero (q == 0); tc one-cycle terminal-count
//           pulse; err sticky invalid-load flag (cleared by a valid load).
module bcd_down_ctr
  import bcd_down_ctr_pkg::*;
#(
  parameter int DIGITS = 2  // legal range 1..DIGITS_MAX
) (
  input  logic                clk,
  input  logic                res,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  input  logic                wrap,
  output logic [4*DIGITS-1:0] q,
  output logic                zero,
  output logic                tc,
  output logic                err
);

  logic [DIGITS-1:0] dig_ok;     // din digit i is a legal BCD value
  logic [DIGITS-1:0] dig_zero;   // q digit i reads 0
  logic [DIGITS-1:0] borrow_ok;  // every digit below i reads 0
  logic              load_ok;
  logic              upper_zero; // every digit above digit 0 reads 0
  logic              is_one;
  logic              dec;

  // Load validity: a single bad nibble rejects the whole load.
  always_comb begin
    dig_ok = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_ok[i] = bcd_valid(din[4*i +: 4]);
    end
  end

  assign load_ok = &dig_ok;

  // Borrow chain: digit i only steps once all lower digits are at zero. The chain
  // is a plain AND of per-digit zero detects, so a 1000 -> 0999 borrow ripples
  // through in a single edge.
  assign borrow_ok[0] = 1'b1;

  genvar g;
  generate
    for (g = 1; g < DIGITS; g++) begin : g_borrow
      assign borrow_ok[g] = borrow_ok[g-1] & dig_zero[g-1];
    end
  endgenerate

  assign zero = &dig_zero;

  // q == 1 detect for tc: digit 0 reads 1 and every higher digit reads 0.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      upper_zero = upper_zero & dig_zero[i];
    end
  end

  assign is_one = (q[3:0] == 4'd1) && upper_zero;

  // A decrement happens when enabled, not overridden by load, and not parked at
  // zero in hold mode. In wrap mode every digit sees borrow_ok with all zeros
  // below it, so 0 rolls to all nines through the normal digit step.
  assign dec = en && !load && (wrap || !zero);

  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_dn_digit u_digit (
        .clk          (clk),
        .res          (res),
        .ld           (load && load_ok),
        .ld_val       (din[4*g +: 4]),
        .step         (dec),
        .borrow_in_ok (borrow_ok[g]),
        .d            (q[4*g +: 4]),
        .is_zero      (dig_zero[g])
      );
    end
  endgenerate

  // tc is a single-cycle pulse on the 1 -> 0 edge only; the 0 -> all-nines wrap
  // never qualifies because is_one is false at zero. Any load clears it.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tc <= 1'b0;
    end else begin
      tc <= dec && is_one;
    end
  end

  // err is sticky across counting and only a valid load (or reset) clears it.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      err <= 1'b0;
    end else if (load) begin
      err <= !load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_down_ctr.sv
module tb_bcd_down_ctr;

  logic        clk = 1'b0;
  logic        res;
  logic        en, load, wrap;
  logic [7:0]  din, q;
  logic        zero, tc, err;
  logic        en4, load4, wrap4;
  logic [15:0] din4, q4;
  logic        zero4, tc4, err4;

  always #5 clk = ~clk;

  bcd_down_ctr #(.DIGITS(2)) u_dut2 (
    .clk(clk), .res(res), .en(en), .load(load), .din(din), .wrap(wrap),
    .q(q), .zero(zero), .tc(tc), .err(err)
  );

  bcd_down_ctr #(.DIGITS(4)) u_dut4 (
    .clk(clk), .res(res), .en(en4), .load(load4), .din(din4), .wrap(wrap4),
    .q(q4), .zero(zero4), .tc(tc4), .err(err4)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: the count held as a plain integer.
  int m2_val = 0, m4_val = 0;
  bit m2_err = 0, m4_err = 0, m2_tc = 0, m4_tc = 0;

  typedef struct {
    bit         ld;
    bit         en;
    bit         wr;
    logic [7:0] di;
    logic [7:0] eq;
    bit         etc;
    bit         eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [31:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int x, input int nd);
    logic [31:0] r = '0;
    int y = x;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [31:0] v, input int nd);
    bit ok = 1;
    for (int i = 0; i < nd; i++) if (v[4*i +: 4] > 4'd9) ok = 0;
    return ok;
  endfunction

  task automatic model_step(input int nd, input bit l, input bit e, input bit w,
                            input logic [31:0] d, inout int val, inout bit er, inout bit t);
    int maxv = 1;
    for (int i = 0; i < nd; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    if (l) begin
      t = 0;
      if (bcd_ok(d, nd)) begin
        val = bcd2int(d, nd);
        er  = 0;
      end else begin
        er = 1;
      end
    end else if (e) begin
      if (val == 0) begin
        t = 0;
        if (w) val = maxv;
      end else begin
        t   = (val == 1);
        val = val - 1;
      end
    end else begin
      t = 0;
    end
  endtask

  task automatic cyc(input bit l, input bit e, input bit w, input logic [7:0] d,
                     input bit l4, input bit e4, input bit w4, input logic [15:0] d4);
    load = l;  en = e;  wrap = w;  din = d;
    load4 = l4; en4 = e4; wrap4 = w4; din4 = d4;
    @(posedge clk);
    #1;
    model_step(2, l, e, w, {24'b0, d}, m2_val, m2_err, m2_tc);
    model_step(4, l4, e4, w4, {16'b0, d4}, m4_val, m4_err, m4_tc);
  endtask

  task automatic cyc2(input bit l, input bit e, input bit w, input logic [7:0] d);
    cyc(l, e, w, d, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic model_reset();
    m2_val = 0; m2_err = 0; m2_tc = 0;
    m4_val = 0; m4_err = 0; m4_tc = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_q2"},    {24'b0, q},  int2bcd(m2_val, 2));
    chk({tag, "_tc2"},   tc,          m2_tc);
    chk({tag, "_err2"},  err,         m2_err);
    chk({tag, "_zero2"}, zero,        (m2_val == 0));
    chk({tag, "_q4"},    {16'b0, q4}, int2bcd(m4_val, 4));
    chk({tag, "_tc4"},   tc4,         m4_tc);
    chk({tag, "_err4"},  err4,        m4_err);
    chk({tag, "_zero4"}, zero4,       (m4_val == 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    res = 1'b0;
    en = 0; load = 0; wrap = 0; din = '0;
    en4 = 0; load4 = 0; wrap4 = 0; din4 = '0;
    model_reset();
    #3;
    chk("rst_q",    {24'b0, q}, 32'h0);
    chk("rst_zero", zero,       1'b1);
    chk("rst_tc",   tc,         1'b0);
    chk("rst_err",  err,        1'b0);
    #9 res = 1'b1;   // released between edges

    // Table-driven directed vectors, applied in sequence from the reset state.
    tbl.push_back('{1, 0, 0, 8'h25, 8'h25, 0, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h24, 0, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 8'h24, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h37, 8'h37, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h3A, 8'h37, 0, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h36, 0, 1});
    tbl.push_back('{1, 0, 0, 8'hA0, 8'h36, 0, 1});
    tbl.push_back('{1, 0, 0, 8'h40, 8'h40, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h05, 8'h05, 0, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h04, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h01, 8'h01, 0, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 1, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 1, 8'h00, 8'h99, 0, 0});
    tbl.push_back('{0, 1, 1, 8'h00, 8'h98, 0, 0});
    tbl.push_back('{1, 0, 1, 8'h10, 8'h10, 0, 0});
    tbl.push_back('{0, 1, 1, 8'h00, 8'h09, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h01, 8'h01, 0, 0});
    tbl.push_back('{0, 1, 0, 8'h00, 8'h00, 1, 0});
    tbl.push_back('{1, 0, 0, 8'h07, 8'h07, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h20, 8'h20, 0, 0});
    tbl.push_back('{1, 0, 0, 8'h9F, 8'h20, 0, 1});
    tbl.push_back('{1, 1, 0, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{0, 0, 1, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{1, 0, 1, 8'h99, 8'h99, 0, 0});
    tbl.push_back('{0, 1, 1, 8'h00, 8'h98, 0, 0});
    foreach (tbl[k]) begin
      cyc2(tbl[k].ld, tbl[k].en, tbl[k].wr, tbl[k].di);
      chk($sformatf("vec%0d_q", k),    {24'b0, q}, {24'b0, tbl[k].eq});
      chk($sformatf("vec%0d_tc", k),   tc,         tbl[k].etc);
      chk($sformatf("vec%0d_err", k),  err,        tbl[k].eerr);
      chk($sformatf("vec%0d_zero", k), zero,       (tbl[k].eq == 8'h00));
    end

    // Countdown in hold mode: 12 then 15 enabled edges, exactly one tc at first 00.
    cyc2(1, 0, 0, 8'h12);
    pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      cyc2(0, 1, 0, 8'h00);
      chk($sformatf("hold%0d_q", k), {24'b0, q}, int2bcd((k >= 12) ? 0 : 12 - k, 2));
      chk($sformatf("hold%0d_tc", k), tc, (k == 12));
      if (tc) pulses++;
    end
    chk("hold_tc_pulses", pulses, 1);

    // Borrow and wrap: 10 -> 09 .. 00, 99, 98 with tc only at 00.
    cyc2(1, 0, 1, 8'h10);
    for (int k = 1; k <= 12; k++) begin
      int e;
      e = (k <= 10) ? 10 - k : 110 - k;
      cyc2(0, 1, 1, 8'h00);
      chk($sformatf("wrap%0d_q", k), {24'b0, q}, int2bcd(e, 2));
      chk($sformatf("wrap%0d_tc", k), tc, (k == 10));
    end

    // Reset landing in the tc cycle: tc and q drop with no clock edge.
    cyc2(1, 0, 0, 8'h01);
    cyc2(0, 1, 0, 8'h00);
    chk("pre_rst_tc", tc, 1'b1);
    #2 res = 1'b0;
    #1;
    chk("async_rst_tc",   tc,         1'b0);
    chk("async_rst_q",    {24'b0, q}, 32'h0);
    chk("async_rst_zero", zero,       1'b1);
    model_reset();
    #3 res = 1'b1;
    cyc2(0, 1, 0, 8'h00);
    chk("post_rst_hold_q",  {24'b0, q}, 32'h0);
    chk("post_rst_hold_tc", tc,         1'b0);
    cyc2(1, 0, 0, 8'h25);
    chk("post_rst_load_q",   {24'b0, q}, 32'h25);
    chk("post_rst_load_err", err,        1'b0);

    // Four decades: 1000 -> 0999 in one edge, then down to zero with one tc.
    cyc(0, 0, 0, 8'h00, 1, 0, 0, 16'h1000);
    chk("d4_load_q", {16'b0, q4}, 32'h1000);
    cyc(0, 0, 0, 8'h00, 0, 1, 0, 16'h0);
    chk("d4_borrow_q", {16'b0, q4}, 32'h0999);
    pulses = 0;
    for (int k = 2; k <= 1000; k++) begin
      cyc(0, 0, 0, 8'h00, 0, 1, 0, 16'h0);
      if (tc4) pulses++;
    end
    chk("d4_final_q",    {16'b0, q4}, 32'h0);
    chk("d4_final_zero", zero4,       1'b1);
    chk("d4_tc_pulses",  pulses,      1);

    // Randomized traffic on both instances against the integer model.
    for (int k = 0; k < 600; k++) begin
      bit          l, e, w, l4, e4, w4;
      logic [7:0]  d;
      logic [15:0] d4;
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1);
      d  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(int2bcd($urandom_range(0, 15), 2));
      l4 = ($urandom_range(0, 9) == 0);
      e4 = ($urandom_range(0, 3) != 0);
      w4 = $urandom_range(0, 1);
      d4 = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(int2bcd($urandom_range(0, 30), 4));
      cyc(l, e, w, d, l4, e4, w4, d4);
      chk_model($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_down_ctr.md
# bcd_down_ctr

Cascadable N-digit BCD down counter with parallel load, the counting-down counterpart of the team's mod-10 up counter. Each decade counts 9→0 and borrows into the next decade. Used as a programmable interval or timeout timer: software or an upstream FSM loads a BCD value, and the block counts it down to zero and flags terminal count. Output digits feed the same BCD display and decode path as the up counter.

## Interface
Parameters:
- DIGITS, 2: number of BCD decades; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  reset; asynchronous, active-low.
- en  in  1  count enable; decrement by one per clock while high.
- load  in  1  parallel load strobe; has priority over en.
- din  in  4*DIGITS  load value; digit i occupies bits [4i+3:4i], and digit 0 is least significant.
- wrap  in  1  1: from zero, the count wraps to all-nines. 0: the count holds at zero.
- q  out  4*DIGITS  current count, BCD, same digit packing as din.
- zero  out  1  high when q is all zeros; decoded from the registers.
- tc  out  1  terminal-count pulse; registered, one cycle wide.
- err  out  1  invalid-load flag; registered.

## Operation
- Reset (res=0, asynchronous): q=0, tc=0, err=0. zero is therefore 1.
- Priority in each cycle: load, then en, then hold.
- Load with every din digit ≤9:
  - q←din.
  - err←0.
  - tc←0.
- Load with any din digit >9 (A–F):
  - q is unchanged.
  - err←1.
  - tc←0.
  - err stays 1 until the next valid load or reset.
- Decrement (en=1, load=0):
  - Digit 0 always steps.
  - Digit i steps only when digits 0..i-1 are all 0 (borrow chain).
  - A stepping digit at 0 becomes 9. Otherwise it becomes d-1.
- Decrement with q=0:
  - wrap=1: q←all nines (e.g. 99 for DIGITS=2).
  - wrap=0: q stays 0.
- tc:
  - Set to 1 on the edge where a decrement moves q from 1 to 0.
  - Cleared on the next edge.
  - In wrap mode, a wrap from 0 to all-nines does not pulse tc.
- Continuous en with wrap=0 produces exactly one tc pulse per load.
- en=0 with load=0: all registers hold.

## Timing
- q, tc and err update on the clock edge where load or en is sampled; the latency is 1 cycle.
- zero is combinational from q. It changes in the same cycle as q, with no added latency.
- Back-to-back loads are allowed; the last load wins.
- A load in the cycle after the tc edge is legal. The load takes effect and clears tc on the next edge.
- Reset mid-count aborts immediately: q=0 and tc=0 with no clock needed. Counting resumes only after res=1 and a load or en.
- Reset releases asynchronously. The first active edge after release behaves as a normal cycle from q=0.
- The borrow chain is combinational across all digits. The DIGITS=8 critical path is one 4-bit zero-detect per lower digit, AND-chained.

## Structure
Shared package:
- BCD_MAX = 4'd9.
- BCD_ZERO = 4'd0.
- A function that checks a 4-bit BCD digit for validity (≤9).
- The same constants and function are reused by the mod-10 up counter's BCD decode.

Sub-module:
- bcd_dn_digit: one decade.
- Ports: clk, res, ld, ld_val[3:0], step, borrow_in_ok (all lower digits zero), d[3:0], is_zero.
- Instantiated DIGITS times with a generate loop.

Top-level logic:
- Load validity check across all digits.
- Borrow chain.
- q==1 detect for tc.
- wrap/hold gating.
- err and tc registers.

## Test plan
- Reset and load (DIGITS=2): assert res=0 mid-run, release, then load din=8'h25.
  - After reset: q=00, zero=1.
  - After the load edge: q=25, err=0.
- Countdown with hold (wrap=0): load 12, then en=1 for 15 cycles.
  - q runs 11,10,09,…,01,00, then stays 00.
  - tc is high for exactly one cycle, the cycle q first reads 00.
- Borrow and wrap (wrap=1): load 10, then en=1.
  - q runs 09, …, 00, 99, 98.
  - tc pulses once, at 00 only; there is no tc at 99.
- Invalid load: load 8'h37, then load 8'h3A.
  - After the 3A load, q stays 37 and err=1.
  - A following load of 8'h40 gives q=40 and err=0.
- Simultaneous events:
  - load=1 and en=1 together with din=8'h05: q=05, not 04.
  - res asserted in the same cycle as tc: tc drops immediately.
- Scaling (DIGITS=4): load 1000 and count.
  - Next value is 0999, with three-digit borrow in one edge.
  - After 1000 enabled cycles from load, zero=1 and there is one tc pulse.
